// File: rtl/mat_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential matrix multiplier.
// The master side issues start with operands; the slave side returns the result and status.
interface mat_mult_seq_if #(
    parameter int MAT_SIZE = 2,
    parameter int DAT_SIZE = 8,
    parameter int ACC_W    = 2*DAT_SIZE + $clog2(MAT_SIZE)
) ();
    logic                                 start;
    logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0] mat_a;
    logic [MAT_SIZE*MAT_SIZE*DAT_SIZE-1:0] mat_b;
    logic [MAT_SIZE*MAT_SIZE*ACC_W-1:0]    mat_c;
    logic                                 busy;
    logic                                 done;

    modport master (output start, mat_a, mat_b, input mat_c, busy, done);
    modport slave  (input start, mat_a, mat_b, output mat_c, busy, done);
endinterface

// File: rtl/mat_mult_seq.sv
// Sequential NxN unsigned matrix multiplier: one multiply-accumulate per cycle,
// operands captured on start, result published atomically with a one-cycle done pulse.
module mat_mult_seq #(
    parameter int MAT_SIZE = 2,
    parameter int DAT_SIZE = 8,
    parameter int ACC_W    = 2*DAT_SIZE + $clog2(MAT_SIZE)
) (
    input logic           clk,
    input logic           rst_n,
    mat_mult_seq_if.slave bus
);
    localparam int NE = MAT_SIZE*MAT_SIZE;
    localparam int IW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;
    localparam int PW = 2*DAT_SIZE;
    localparam logic [IW-1:0] LAST = IW'(MAT_SIZE-1);
    localparam logic [EW-1:0] NSZ  = EW'(MAT_SIZE);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [NE*DAT_SIZE-1:0] a_q, b_q;
    logic [NE*ACC_W-1:0]    res_q, c_q;
    logic [IW-1:0]          i_q, j_q, k_q;
    logic [ACC_W-1:0]       acc_q;
    logic                   done_q;
    logic                   busy;
    logic [EW-1:0]          a_idx, b_idx, w_idx;
    logic [PW-1:0]          a_ext, b_ext, prod;

    assign a_idx = EW'(i_q) * NSZ + EW'(k_q);
    assign b_idx = EW'(k_q) * NSZ + EW'(j_q);
    assign w_idx = EW'(i_q) * NSZ + EW'(j_q);
    assign a_ext = PW'(a_q[a_idx*DAT_SIZE +: DAT_SIZE]);
    assign b_ext = PW'(b_q[b_idx*DAT_SIZE +: DAT_SIZE]);
    assign prod  = a_ext * b_ext;

    assign bus.busy  = busy;
    assign bus.done  = done_q;
    assign bus.mat_c = c_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = MAC;
            MAC: begin
                busy = 1'b1;
                if (k_q == LAST) state_nxt = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                if (i_q == LAST && j_q == LAST) state_nxt = DONE;
                else                            state_nxt = MAC;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mat_c only changes in DONE, so a run cut short by reset never leaks partial sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            c_q    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.mat_a;
                        b_q   <= bus.mat_b;
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                        acc_q <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    if (k_q != LAST) k_q <= k_q + IW'(1);
                end
                WRITE: begin
                    res_q[w_idx*ACC_W +: ACC_W] <= acc_q;
                    acc_q <= '0;
                    k_q   <= '0;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == LAST) ? '0 : i_q + IW'(1);
                    end else begin
                        j_q <= j_q + IW'(1);
                    end
                end
                DONE: begin
                    c_q    <= res_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
